// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   pll_rst_state_t : sequencer state encoding
//   RETRY_W         : width of the retry and lock-loss counters
//   cnt_w()         : bits needed to count 0 .. max_count-1
package pll_reset_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } pll_rst_state_t;

  localparam int unsigned RETRY_W = 8;

  // Width of a counter that must reach max_count-1; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_count);
    if (max_count < 32'd2) return 32'd1;
    return 32'($clog2(max_count));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : async active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two destination edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer on the free-running board reference clock.
// Holds the PLL in reset, waits for lock, qualifies it as stable, then
// releases the system reset; re-arms the PLL on lock loss and declares a
// fault once lock timeouts reach MAX_RETRIES.
// Optional feature macro: PLL_RESET_CTRL_LOSS_CNT_EN enables lock_loss_cnt.
//   refclk        : board reference clock
//   rst_n         : async active-low reset
//   pll_locked    : PLL lock indicator, asynchronous to refclk
//   soft_reset    : one-cycle request to restart the whole sequence
//   pll_rst       : PLL reset, active-high
//   sys_rst_n     : system reset, active-low
//   fault         : retries exhausted
//   retry_cnt     : lock timeouts since the last successful release
//   lock_loss_cnt : lock losses seen while running (0 when feature is off)
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_reset,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [RETRY_W-1:0] lock_loss_cnt
);

  localparam int unsigned CNT_MAX =
    (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
      ((PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES) :
      ((LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES);
  localparam int unsigned CNT_W = cnt_w(CNT_MAX);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] CNT8_SAT     = '1;

  pll_rst_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d, retry_inc;
  logic               lock_s;

  // Lock indicator crosses into refclk here; only lock_s is used below.
  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_cnt;
    retry_inc = (retry_cnt == CNT8_SAT) ? retry_cnt : retry_cnt + RETRY_W'(1);

    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_PLL_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // A lock drop while qualifying only restarts the wait, not a retry.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Software restart overrides every other transition.
    if (soft_reset) begin
      state_d = S_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // State register; outputs are decoded from the next state so they are
  // registered and change on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      pll_rst   <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
      sys_rst_n <= (state_d == S_RUN);
      fault     <= (state_d == S_FAULT);
    end
  end

`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
  // Counts RUN exits caused by lock loss, even if soft_reset coincides.
  logic               lock_loss_c;
  logic [RETRY_W-1:0] loss_cnt_q;

  assign lock_loss_c = (state_q == S_RUN) && !lock_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (lock_loss_c && (loss_cnt_q != CNT8_SAT)) begin
      loss_cnt_q <= loss_cnt_q + RETRY_W'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
